dct_rle_encoder: RTL

Consumes the quantized, zig-zag-ordered 8x8 coefficient stream produced by `dct_top` (`m_tdata`/`m_tlast` per block). It converts each block into JPEG baseline run-length symbols (run, size, amplitude), with DC coded as a difference from the previous block. Its output feeds the Huffman coder.

---
 rtl/dct_pkg.sv | 26 ++
 rtl/dct_vli_encode.sv | 29 ++
 rtl/dct_rle_encoder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/dct_pkg.sv
// Shared types and constants for the DCT run-length encoder slice.
// Symbol and coefficient widths here match the encoder's default parameters.
package dct_pkg;

  localparam int COEFF_W = 12;
  localparam int AMP_W = COEFF_W + 1;
  localparam logic [3:0] ZRL_RUN = 4'd15;
  localparam int BLOCK_LEN = 64;

  typedef logic signed [COEFF_W-1:0] coeff_t;

  typedef struct packed {
    logic [3:0]       run;
    logic [3:0]       size;
    logic [AMP_W-1:0] amp;
    logic             is_dc;
    logic             last;
  } rle_sym_t;

  typedef enum logic [1:0] {
    ST_DC  = 2'd0,
    ST_AC  = 2'd1,
    ST_ZRL = 2'd2
  } rle_state_t;

endpackage

// File: rtl/dct_vli_encode.sv
// JPEG variable-length-integer encoding: magnitude category and amplitude bits.
// Negative values are coded as (v-1) truncated to the category width.
module dct_vli_encode #(
  parameter int W = 13
) (
  input  logic signed [W-1:0] value,
  output logic [3:0]          size,
  output logic [W-1:0]        amp
);

  logic [W-1:0] mag;
  logic [W-1:0] mask;
  logic [W-1:0] minus1;

  always_comb begin
    mag = value[W-1] ? -value : value;
    size = '0;
    for (int i = 0; i < W; i++) begin
      if (mag[i]) size = 4'(i + 1);
    end
    mask = '0;
    for (int i = 0; i < W; i++) begin
      mask[i] = (4'(i) < size);
    end
    minus1 = value - W'(1);
    amp = value[W-1] ? (minus1 & mask) : value;
  end

endmodule

// File: rtl/dct_rle_encoder.sv
// Converts zig-zag ordered 8x8 quantized coefficients into JPEG (run, size, amp)
// symbols with DC prediction, ZRL expansion and end-of-block handling.
//
// state  | meaning
// ST_DC  | waiting for index 0 of a block (DC coefficient)
// ST_AC  | consuming AC indices 1..63, counting zero runs
// ST_ZRL | input stalled, emitting ZRLs then the held coefficient's symbol
module dct_rle_encoder
  import dct_pkg::*;
#(
  parameter int COEFF_WIDTH = COEFF_W,
  parameter int AMP_WIDTH   = COEFF_WIDTH + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COEFF_WIDTH-1:0] s_tdata,
  input  logic                   s_tvalid,
  output logic                   s_tready,
  input  logic                   s_tlast,
  input  logic                   dc_clear,
  output logic [3:0]             m_run,
  output logic [3:0]             m_size,
  output logic [AMP_WIDTH-1:0]   m_amp,
  output logic                   m_is_dc,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic                   m_tlast,
  output logic                   err_tlast
);

  rle_state_t state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [5:0] zrun_q, zrun_d;
  logic [1:0] zrl_rem_q, zrl_rem_d;
  coeff_t     prev_dc_q, prev_dc_d;
  coeff_t     held_q, held_d;
  logic       held_last_q, held_last_d;
  rle_sym_t   sym_q, sym_d;
  logic       valid_q, sym_load;
  logic       err_q;

  logic       out_free, accept, is_last_idx;
  logic signed [AMP_WIDTH-1:0] in_ext, prev_ext, held_ext, vli_in;
  logic [3:0]           vli_size;
  logic [AMP_WIDTH-1:0] vli_amp;

  assign out_free    = !valid_q || m_tready;
  assign s_tready    = rst_n && out_free && (state_q != ST_ZRL);
  assign accept      = s_tvalid && s_tready;
  assign is_last_idx = (idx_q == 6'(BLOCK_LEN - 1));

  assign in_ext   = {{(AMP_WIDTH-COEFF_WIDTH){s_tdata[COEFF_WIDTH-1]}}, s_tdata};
  assign prev_ext = {{(AMP_WIDTH-COEFF_W){prev_dc_q[COEFF_W-1]}}, prev_dc_q};
  assign held_ext = {{(AMP_WIDTH-COEFF_W){held_q[COEFF_W-1]}}, held_q};

  always_comb begin
    case (state_q)
      ST_DC:   vli_in = in_ext - (dc_clear ? '0 : prev_ext);
      ST_ZRL:  vli_in = held_ext;
      default: vli_in = in_ext;
    endcase
  end

  dct_vli_encode #(.W(AMP_WIDTH)) u_vli (
    .value(vli_in),
    .size (vli_size),
    .amp  (vli_amp)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    zrun_d      = zrun_q;
    zrl_rem_d   = zrl_rem_q;
    prev_dc_d   = prev_dc_q;
    held_d      = held_q;
    held_last_d = held_last_q;
    sym_d       = '0;
    sym_load    = 1'b0;
    case (state_q)
      ST_DC: begin
        if (accept) begin
          sym_load    = 1'b1;
          sym_d.size  = vli_size;
          sym_d.amp   = vli_amp;
          sym_d.is_dc = 1'b1;
          prev_dc_d   = s_tdata;
          idx_d       = idx_q + 6'd1;
          zrun_d      = '0;
          state_d     = ST_AC;
        end
      end
      ST_AC: begin
        if (accept) begin
          idx_d = idx_q + 6'd1;
          if (s_tdata == '0) begin
            if (is_last_idx) begin
              sym_load   = 1'b1;
              sym_d.last = 1'b1;
              zrun_d     = '0;
              state_d    = ST_DC;
            end else begin
              zrun_d = zrun_q + 6'd1;
            end
          end else if (zrun_q[5:4] == 2'd0) begin
            sym_load   = 1'b1;
            sym_d.run  = zrun_q[3:0];
            sym_d.size = vli_size;
            sym_d.amp  = vli_amp;
            sym_d.last = is_last_idx;
            zrun_d     = '0;
            if (is_last_idx) state_d = ST_DC;
          end else begin
            // First ZRL goes out with the accept; the rest drain in ST_ZRL.
            sym_load    = 1'b1;
            sym_d.run   = ZRL_RUN;
            held_d      = s_tdata;
            held_last_d = is_last_idx;
            zrl_rem_d   = zrun_q[5:4] - 2'd1;
            zrun_d      = {2'b00, zrun_q[3:0]};
            state_d     = ST_ZRL;
          end
        end
      end
      ST_ZRL: begin
        if (out_free) begin
          sym_load = 1'b1;
          if (zrl_rem_q != 2'd0) begin
            sym_d.run = ZRL_RUN;
            zrl_rem_d = zrl_rem_q - 2'd1;
          end else begin
            sym_d.run  = zrun_q[3:0];
            sym_d.size = vli_size;
            sym_d.amp  = vli_amp;
            sym_d.last = held_last_q;
            zrun_d     = '0;
            state_d    = held_last_q ? ST_DC : ST_AC;
          end
        end
      end
      default: state_d = ST_DC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_DC;
      idx_q       <= '0;
      zrun_q      <= '0;
      zrl_rem_q   <= '0;
      prev_dc_q   <= '0;
      held_q      <= '0;
      held_last_q <= 1'b0;
      sym_q       <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      zrun_q      <= zrun_d;
      zrl_rem_q   <= zrl_rem_d;
      prev_dc_q   <= prev_dc_d;
      held_q      <= held_d;
      held_last_q <= held_last_d;
      err_q       <= accept && (s_tlast != is_last_idx);
      if (out_free) begin
        sym_q   <= sym_d;
        valid_q <= sym_load;
      end
    end
  end

  assign m_run     = sym_q.run;
  assign m_size    = sym_q.size;
  assign m_amp     = sym_q.amp;
  assign m_is_dc   = sym_q.is_dc;
  assign m_tlast   = sym_q.last;
  assign m_tvalid  = valid_q;
  assign err_tlast = err_q;

endmodule
